// File: rtl/hier_pkg.sv
// Shared definitions for the hierarchy fan-in/fan-out tree nodes.
// Holds the default node width (matching the inst_0..inst_4 fan-out), the
// default payload width, and the child index type at the default width.
package hier_pkg;

   localparam int HIER_NUM_CHILDREN = 5;
   localparam int HIER_DATA_W       = 8;
   localparam int HIER_IDX_W        = $clog2(HIER_NUM_CHILDREN);

   typedef logic [HIER_IDX_W-1:0] child_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin arbiter.
// Searches the request vector starting at ptr_i and wrapping modulo N, and
// returns a one-hot grant plus its index. Purely combinational; the caller
// owns the pointer register and decides when to advance it.
//   req_i       : N-bit request vector
//   ptr_i       : index that has highest priority this cycle (0..N-1)
//   grant_o     : one-hot grant, zero when no request
//   grant_idx_o : index of the granted request (0 when none)
//   grant_vld_o : any request granted
module rr_arbiter
   import hier_pkg::*;
#(
   parameter  int N     = HIER_NUM_CHILDREN,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] grant_idx_o,
   output logic             grant_vld_o
);

   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int unsigned      off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= 32'(N)) s = s - 32'(N);
      return s[IDX_W-1:0];
   endfunction

   logic [IDX_W-1:0] cand;

   // Scan from the lowest-priority offset down to the pointer so that the
   // last hit, which wins, is the one closest to ptr_i.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      grant_vld_o = 1'b0;
      cand        = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = wrap_add(ptr_i, k);
         if (req_i[cand]) begin
            grant_vld_o = 1'b1;
            grant_idx_o = cand;
         end
      end
      if (grant_vld_o) grant_o[grant_idx_o] = 1'b1;
   end

endmodule

// File: rtl/hier_fanin_collector.sv
// Hierarchy fan-in node: merges status beats from NUM_CHILDREN children into
// one tagged stream toward the parent, with fair round-robin selection, a
// one-entry output buffer and round tracking.
//   clk, rst_n   : clock, asynchronous active-low reset
//   child_valid  : per-child beat valid
//   child_data   : per-child payload, child i at [i*DATA_W +: DATA_W]
//   child_ready  : per-child accept, one-hot or zero
//   up_valid     : merged beat valid
//   up_data      : merged payload
//   up_idx       : originating child of the merged beat
//   up_ready     : parent accepts the beat
//   round_done   : one-cycle pulse when every child has reported
//   round_cnt    : completed-round count (wraps)
module hier_fanin_collector
   import hier_pkg::*;
#(
   parameter  int NUM_CHILDREN = HIER_NUM_CHILDREN,
   parameter  int DATA_W       = HIER_DATA_W,
   parameter  int RCNT_W       = 16,
   localparam int IDX_W        = $clog2(NUM_CHILDREN)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_CHILDREN-1:0]        child_valid,
   input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
   output logic [NUM_CHILDREN-1:0]        child_ready,
   output logic                           up_valid,
   output logic [DATA_W-1:0]              up_data,
   output logic [IDX_W-1:0]               up_idx,
   input  logic                           up_ready,
   output logic                           round_done,
   output logic [RCNT_W-1:0]              round_cnt
);

   localparam logic [NUM_CHILDREN-1:0] ALL_SEEN = '1;
   localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_CHILDREN - 1);

   logic                    up_valid_q,   up_valid_d;
   logic [DATA_W-1:0]       up_data_q,    up_data_d;
   logic [IDX_W-1:0]        up_idx_q,     up_idx_d;
   logic [IDX_W-1:0]        ptr_q,        ptr_d;
   logic [NUM_CHILDREN-1:0] seen_q,       seen_d;
   logic                    round_done_q, round_done_d;
   logic [RCNT_W-1:0]       round_cnt_q,  round_cnt_d;

   logic                    buf_free;
   logic [NUM_CHILDREN-1:0] arb_req;
   logic [NUM_CHILDREN-1:0] grant;
   logic [IDX_W-1:0]        grant_idx;
   logic                    accept;
   logic [NUM_CHILDREN-1:0] seen_set;

   // The buffer can take a new beat when empty or when it drains this cycle.
   // Requests are masked during reset so child_ready is held low.
   assign buf_free = !up_valid_q || up_ready;
   assign arb_req  = child_valid & {NUM_CHILDREN{buf_free & rst_n}};

   rr_arbiter #(
      .N (NUM_CHILDREN)
   ) u_arb (
      .req_i       (arb_req),
      .ptr_i       (ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .grant_vld_o (accept)
   );

   assign child_ready = grant;
   assign seen_set    = seen_q | grant;

   always_comb begin
      up_valid_d   = up_valid_q;
      up_data_d    = up_data_q;
      up_idx_d     = up_idx_q;
      ptr_d        = ptr_q;
      seen_d       = seen_q;
      round_done_d = 1'b0;
      round_cnt_d  = round_cnt_q;
      if (accept) begin
         // Covers the drain-and-refill case too: the new beat overwrites.
         up_valid_d = 1'b1;
         up_data_d  = child_data[int'(grant_idx)*DATA_W +: DATA_W];
         up_idx_d   = grant_idx;
         ptr_d      = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
         if (seen_set == ALL_SEEN) begin
            round_done_d = 1'b1;
            seen_d       = '0;
            round_cnt_d  = round_cnt_q + 1'b1;
         end else begin
            seen_d = seen_set;
         end
      end else if (up_ready) begin
         up_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_valid_q   <= 1'b0;
         up_data_q    <= '0;
         up_idx_q     <= '0;
         ptr_q        <= '0;
         seen_q       <= '0;
         round_done_q <= 1'b0;
         round_cnt_q  <= '0;
      end else begin
         up_valid_q   <= up_valid_d;
         up_data_q    <= up_data_d;
         up_idx_q     <= up_idx_d;
         ptr_q        <= ptr_d;
         seen_q       <= seen_d;
         round_done_q <= round_done_d;
         round_cnt_q  <= round_cnt_d;
      end
   end

   assign up_valid   = up_valid_q;
   assign up_data    = up_data_q;
   assign up_idx     = up_idx_q;
   assign round_done = round_done_q;
   assign round_cnt  = round_cnt_q;

endmodule

// File: tb/tb_hier_fanin_collector.sv
// Bench for hier_fanin_collector: behavioural children feed per-child beat
// queues, a cycle model predicts grants and pushes expected beats into a
// scoreboard that is popped as the parent drains them.
module tb_hier_fanin_collector;
   import hier_pkg::*;

   localparam int N      = 5;
   localparam int DW     = 8;
   localparam int IW     = $clog2(N);
   localparam int RCNT_W = 3;
   localparam int RMOD   = 1 << RCNT_W;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } beat_t;

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      child_valid;
   logic [N*DW-1:0]   child_data;
   logic [N-1:0]      child_ready;
   logic              up_valid;
   logic [DW-1:0]     up_data;
   logic [IW-1:0]     up_idx;
   logic              up_ready;
   logic              round_done;
   logic [RCNT_W-1:0] round_cnt;

   hier_fanin_collector #(
      .NUM_CHILDREN (N),
      .DATA_W       (DW),
      .RCNT_W       (RCNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .child_valid (child_valid),
      .child_data  (child_data),
      .child_ready (child_ready),
      .up_valid    (up_valid),
      .up_data     (up_data),
      .up_idx      (up_idx),
      .up_ready    (up_ready),
      .round_done  (round_done),
      .round_cnt   (round_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Children and model state
   logic [7:0] cq [N][$];
   beat_t      sb [$];
   child_idx_t drained [$];
   int         m_ptr, m_rc, obs_rd;
   logic       m_uv, m_rd;
   logic [N-1:0] m_seen;
   logic       pop_vld;
   int         pop_idx;

   initial begin
      m_ptr = 0; m_rc = 0; obs_rd = 0; m_uv = 0; m_rd = 0; m_seen = '0;
      pop_vld = 0; pop_idx = 0;
   end

   task automatic drive_children();
      for (int i = 0; i < N; i++) begin
         child_valid[i] = (cq[i].size() > 0);
         child_data[i*DW +: DW] = (cq[i].size() > 0) ? cq[i][0] : 8'h00;
      end
   endtask

   task automatic push_beat(input int i, input logic [7:0] d);
      cq[i].push_back(d);
      drive_children();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (pop_vld) void'(cq[pop_idx].pop_front());
      drive_children();
   endtask

   function automatic bit idle();
      for (int i = 0; i < N; i++) if (cq[i].size() > 0) return 1'b0;
      return !m_uv;
   endfunction

   task automatic run_until_idle(input int budget, input bit rand_ready);
      bit done;
      done = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (rand_ready) up_ready = 1'($urandom_range(0, 1));
         tick();
         if (idle()) begin
            done = 1'b1;
            break;
         end
      end
      up_ready = 1'b1;
      check_val("drain_timeout", {31'd0, done}, 32'd1);
   endtask

   // Cycle model and scoreboard, evaluated mid-cycle with inputs stable.
   always @(negedge clk) begin
      int g, j;
      logic [N-1:0] nseen;
      if (!rst_n) begin
         check_val("rst_child_ready", 32'(child_ready), 32'd0);
         check_val("rst_up_valid", 32'(up_valid), 32'd0);
         check_val("rst_round_cnt", 32'(round_cnt), 32'd0);
         m_uv = 0; m_ptr = 0; m_seen = '0; m_rd = 0; m_rc = 0;
         sb.delete();
         pop_vld = 0;
      end else begin
         check_val("up_valid", 32'(up_valid), 32'(m_uv));
         if (round_done) obs_rd++;
         if (m_uv) begin
            if (sb.size() == 0) check_val("sb_empty", 32'd1, 32'd0);
            else begin
               check_val("up_idx", 32'(up_idx), 32'(sb[0].idx));
               check_val("up_data", 32'(up_data), 32'(sb[0].data));
            end
         end
         check_val("round_done", 32'(round_done), 32'(m_rd));
         check_val("round_cnt", 32'(round_cnt), 32'(m_rc));
         g = -1;
         if (!m_uv || up_ready) begin
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (g < 0 && child_valid[j]) g = j;
            end
         end
         check_val("child_ready", 32'(child_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
         if (m_uv && up_ready) begin
            if (sb.size() > 0) begin
               drained.push_back(child_idx_t'(sb[0].idx));
               void'(sb.pop_front());
            end
            if (g < 0) m_uv = 0;
         end
         m_rd = 0;
         if (g >= 0) begin
            sb.push_back('{idx: g, data: child_data[g*DW +: DW]});
            m_uv  = 1;
            m_ptr = (g + 1) % N;
            nseen = m_seen | (N'(1) << g);
            if (nseen == '1) begin
               m_rd   = 1;
               m_seen = '0;
               m_rc   = (m_rc + 1) % RMOD;
            end else begin
               m_seen = nseen;
            end
            pop_vld = 1;
            pop_idx = g;
         end else begin
            pop_vld = 0;
         end
      end
   end

   task automatic check_drained(input string tag, input int exp_q [$]);
      check_val({tag, "_len"}, 32'(drained.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < drained.size(); i++)
         check_val(tag, 32'(drained[i]), 32'(exp_q[i]));
   endtask

   initial begin
      int exp_q [$];
      rst_n = 1'b0;
      up_ready = 1'b1;
      child_valid = '0;
      child_data = '0;
      push_beat(1, 8'h11);
      repeat (3) tick();
      for (int i = 0; i < N; i++) cq[i].delete();
      drive_children();
      rst_n = 1'b1;

      // Fairness: all children continuously valid.
      drained.delete();
      obs_rd = 0;
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < N; i++) push_beat(i, 8'(16 * r + i + 8'h40));
      run_until_idle(40, 1'b0);
      exp_q = '{0,1,2,3,4,0,1,2,3,4,0,1,2,3,4};
      check_drained("fair_seq", exp_q);
      check_val("fair_rounds", 32'(obs_rd), 32'd3);

      // Backpressure on child 2, then child 3 waiting behind it.
      drained.delete();
      up_ready = 1'b0;
      push_beat(2, 8'hA5);
      tick();
      push_beat(3, 8'h3C);
      repeat (3) begin
         tick();
         check_val("bp_data", 32'(up_data), 32'h0A5);
         check_val("bp_idx", 32'(up_idx), 32'd2);
         check_val("bp_ready", 32'(child_ready), 32'd0);
      end
      up_ready = 1'b1;
      run_until_idle(20, 1'b0);
      exp_q = '{2,3};
      check_drained("bp_seq", exp_q);

      // Wrap arbitration from ptr=3.
      drained.delete();
      push_beat(2, 8'h22);
      run_until_idle(20, 1'b0);
      push_beat(1, 8'h01);
      push_beat(4, 8'h04);
      run_until_idle(20, 1'b0);
      push_beat(1, 8'h51);
      push_beat(2, 8'h52);
      push_beat(3, 8'h53);
      run_until_idle(20, 1'b0);
      exp_q = '{2,4,1,2,3,1};
      check_drained("wrap_seq", exp_q);

      // Mid-stream reset while a beat is held.
      up_ready = 1'b0;
      push_beat(0, 8'h77);
      push_beat(1, 8'h78);
      tick();
      tick();
      check_val("pre_rst_valid", 32'(up_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("async_up_valid", 32'(up_valid), 32'd0);
      check_val("async_round_cnt", 32'(round_cnt), 32'd0);
      check_val("async_round_done", 32'(round_done), 32'd0);
      check_val("async_child_ready", 32'(child_ready), 32'd0);
      for (int i = 0; i < N; i++) cq[i].delete();
      drive_children();
      up_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      drained.delete();
      push_beat(3, 8'h33);
      push_beat(0, 8'h30);
      run_until_idle(20, 1'b0);
      exp_q = '{0,3};
      check_drained("post_rst_seq", exp_q);

      // Round semantics from a clean reset.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      obs_rd = 0;
      drained.delete();
      for (int b = 0; b < 3; b++) push_beat(0, 8'(8'hC0 + b));
      run_until_idle(20, 1'b0);
      check_val("round_repeat_cnt", 32'(round_cnt), 32'd0);
      for (int i = 1; i < N; i++) push_beat(i, 8'(8'hD0 + i));
      run_until_idle(20, 1'b0);
      check_val("round_pulses", 32'(obs_rd), 32'd1);
      check_val("round_cnt_one", 32'(round_cnt), 32'd1);

      // Counter wrap with random backpressure.
      for (int r = 0; r < RMOD - 1; r++) begin
         for (int i = N - 1; i >= 0; i--) push_beat(i, 8'($urandom_range(0, 255)));
         run_until_idle(100, 1'b1);
      end
      check_val("wrap_pulses", 32'(obs_rd), 32'(RMOD));
      check_val("wrap_round_cnt", 32'(round_cnt), 32'd0);

      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
